// File: rtl/round_timer.sv
// Round countdown timer for a game.
// Counts ROUND_SECONDS down to zero in BCD, one step every TICKS_PER_SEC
// clock cycles while the game is running. Menu reloads the round, pause or
// hold freezes it, and expiry latches until the menu or a reset.
// Every output is a register, so no input reaches an output combinationally.
module round_timer #(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter int unsigned ROUND_SECONDS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gamemenu,
    input  logic       gamerun,
    input  logic       gamepause,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       tick_1hz,
    output logic       time_up,
    output logic       time_up_pulse,
    output logic [1:0] dbg_state_o
);

    // The prescaler is just wide enough to hold TICKS_PER_SEC-1.
    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_TERM = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_ZERO = '0;
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    // Round length split into its two BCD digits.
    localparam logic [3:0] LOAD_TENS = 4'(ROUND_SECONDS / 10);
    localparam logic [3:0] LOAD_ONES = 4'(ROUND_SECONDS % 10);

    typedef enum logic [1:0] {
        ST_LOADED   = 2'd0,
        ST_COUNTING = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_EXPIRED  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q,  tens_d;
    logic [3:0]    ones_q,  ones_d;
    logic          tick_q,  tick_d;
    logic          time_up_q, time_up_d;
    logic          pulse_q, pulse_d;

    // Effective mode, priority menu > pause > run; anything else is hold,
    // which behaves exactly like pause.
    logic mode_menu;
    logic mode_run;
    logic presc_wrap;
    logic last_second;

    assign mode_menu   = gamemenu;
    assign mode_run    = !gamemenu && !gamepause && gamerun;
    assign presc_wrap  = (presc_q == PRESC_TERM);
    assign last_second = (tens_q == 4'd0) && (ones_q == 4'd1);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_LOADED;
            presc_q   <= PRESC_ZERO;
            tens_q    <= LOAD_TENS;
            ones_q    <= LOAD_ONES;
            tick_q    <= 1'b0;
            time_up_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            tick_q    <= tick_d;
            time_up_q <= time_up_d;
            pulse_q   <= pulse_d;
        end
    end

    // Next-state, prescaler, BCD count and pulse generation.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        tick_d    = 1'b0;
        time_up_d = time_up_q;
        pulse_d   = 1'b0;

        if (mode_menu) begin
            // Menu wins over everything, including a terminal count this cycle.
            state_d   = ST_LOADED;
            presc_d   = PRESC_ZERO;
            tens_d    = LOAD_TENS;
            ones_d    = LOAD_ONES;
            time_up_d = 1'b0;
        end else begin
            case (state_q)
                ST_EXPIRED: begin
                    // Latched until menu or reset; count and prescaler parked.
                    presc_d   = PRESC_ZERO;
                    tens_d    = 4'd0;
                    ones_d    = 4'd0;
                    time_up_d = 1'b1;
                end
                default: begin
                    if (mode_run) begin
                        state_d = ST_COUNTING;
                        if (presc_wrap) begin
                            presc_d = PRESC_ZERO;
                            tick_d  = 1'b1;
                            if (last_second) begin
                                ones_d    = 4'd0;
                                state_d   = ST_EXPIRED;
                                time_up_d = 1'b1;
                                pulse_d   = 1'b1;
                            end else if (ones_q == 4'd0) begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end else begin
                                ones_d = ones_q - 4'd1;
                            end
                        end else begin
                            presc_d = presc_q + PRESC_ONE;
                        end
                    end else if (state_q != ST_LOADED) begin
                        // Pause/hold freezes prescaler and count so a resume
                        // continues the partially elapsed second.
                        state_d = ST_PAUSED;
                    end
                end
            endcase
        end
    end

    assign sec_tens      = tens_q;
    assign sec_ones      = ones_q;
    assign tick_1hz      = tick_q;
    assign time_up       = time_up_q;
    assign time_up_pulse = pulse_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer: a 3 s round at 4 ticks/s, plus a 10 s
// round instance sharing the same inputs to exercise the BCD digit borrow.
module tb_round_timer;

    localparam int W = 13;
    localparam logic [1:0] LD = 2'd0;
    localparam logic [1:0] CN = 2'd1;
    localparam logic [1:0] PA = 2'd2;
    localparam logic [1:0] EX = 2'd3;

    logic clk = 1'b0;
    logic reset, gamemenu, gamerun, gamepause;
    logic [3:0] sec_tens, sec_ones, r10_tens, r10_ones;
    logic tick_1hz, time_up, time_up_pulse;
    logic r10_tick, r10_time_up, r10_pulse;
    logic [1:0] dbg_state, r10_state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    round_timer #(.TICKS_PER_SEC(4), .ROUND_SECONDS(3)) dut (
        .clk(clk), .reset(reset), .gamemenu(gamemenu), .gamerun(gamerun),
        .gamepause(gamepause), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .tick_1hz(tick_1hz), .time_up(time_up), .time_up_pulse(time_up_pulse),
        .dbg_state_o(dbg_state)
    );

    round_timer #(.TICKS_PER_SEC(4), .ROUND_SECONDS(10)) dut10 (
        .clk(clk), .reset(reset), .gamemenu(gamemenu), .gamerun(gamerun),
        .gamepause(gamepause), .sec_tens(r10_tens), .sec_ones(r10_ones),
        .tick_1hz(r10_tick), .time_up(r10_time_up), .time_up_pulse(r10_pulse),
        .dbg_state_o(r10_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input int secs, input logic tk,
                                        input logic tu, input logic tp,
                                        input logic [1:0] st);
        logic [3:0] t, o;
        t = 4'(secs / 10);
        o = 4'(secs % 10);
        return {t, o, tk, tu, tp, st};
    endfunction

    task automatic drive(input logic rst, input logic m, input logic p, input logic r);
        reset = rst; gamemenu = m; gamepause = p; gamerun = r;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    function automatic logic [W-1:0] obs_main();
        return {sec_tens, sec_ones, tick_1hz, time_up, time_up_pulse, dbg_state};
    endfunction

    function automatic logic [W-1:0] obs_r10();
        return {r10_tens, r10_ones, r10_tick, r10_time_up, r10_pulse, r10_state};
    endfunction

    initial begin
        // Reset
        drive(1, 0, 0, 0);
        exp_q.push_back(mk(3, 0, 0, 0, LD));
        exp_q.push_back(mk(10, 0, 0, 0, LD));
        step;
        chk("reset", obs_main());
        chk("reset_r10", obs_r10());

        // Idle after reset: no counting without run
        drive(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(3, 0, 0, 0, LD));
            step;
            chk("idle_after_reset", obs_main());
        end

        // Uninterrupted run: ticks at 4, 8, 12; expiry at 12
        drive(0, 0, 0, 1);
        for (int i = 1; i <= 12; i++) begin
            exp_q.push_back(mk(3 - i / 4, (i % 4 == 0), (i == 12), (i == 12),
                               (i == 12) ? EX : CN));
            exp_q.push_back(mk(10 - i / 4, (i % 4 == 0), 0, 0, CN));
            step;
            chk("run_count", obs_main());
            chk("r10_count", obs_r10());
        end

        // Run held in EXPIRED: no ticks, pulse gone after one cycle
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(mk(0, 0, 1, 0, EX));
            step;
            chk("expired_hold", obs_main());
        end

        // One menu cycle leaves EXPIRED and reloads
        drive(0, 1, 0, 1);
        exp_q.push_back(mk(3, 0, 0, 0, LD));
        exp_q.push_back(mk(10, 0, 0, 0, LD));
        step;
        chk("menu_exit", obs_main());
        chk("r10_menu", obs_r10());

        // Run 6 cycles: tick at 4, prescaler left at 2
        drive(0, 0, 0, 1);
        for (int i = 1; i <= 6; i++) begin
            exp_q.push_back(mk((i >= 4) ? 2 : 3, (i == 4), 0, 0, CN));
            step;
            chk("pause_pre", obs_main());
        end

        // Pause (with run still high) for 10 cycles: frozen
        drive(0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(mk(2, 0, 0, 0, PA));
            step;
            chk("paused", obs_main());
        end

        // Resume: tick after 2 run cycles
        drive(0, 0, 0, 1);
        exp_q.push_back(mk(2, 0, 0, 0, CN));
        step;
        chk("resume_1", obs_main());
        exp_q.push_back(mk(1, 1, 0, 0, CN));
        step;
        chk("resume_tick", obs_main());

        // Mid-second at 01
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(1, 0, 0, 0, CN));
            step;
            chk("mid_second", obs_main());
        end

        // Reset mid-round overrides run
        drive(1, 0, 0, 1);
        exp_q.push_back(mk(3, 0, 0, 0, LD));
        step;
        chk("reset_mid", obs_main());

        // No restart without run
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(3, 0, 0, 0, LD));
            step;
            chk("no_restart", obs_main());
        end

        // Run to prescaler = 3
        drive(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(3, 0, 0, 0, CN));
            step;
            chk("pre_menu", obs_main());
        end

        // Menu on the terminal count cycle: no tick, reload
        drive(0, 1, 0, 1);
        exp_q.push_back(mk(3, 0, 0, 0, LD));
        step;
        chk("menu_terminal", obs_main());

        // Prescaler restarted from 0: tick a full 4 cycles later
        drive(0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(mk((i == 4) ? 2 : 3, (i == 4), 0, 0, CN));
            step;
            chk("post_menu", obs_main());
        end

        // Hold (no mode input) acts as pause
        drive(0, 0, 0, 0);
        exp_q.push_back(mk(2, 0, 0, 0, PA));
        step;
        chk("hold_pause", obs_main());

        // Run to expiry from 02
        drive(0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(mk(2 - i / 4, (i % 4 == 0), (i == 8), (i == 8),
                               (i == 8) ? EX : CN));
            step;
            chk("expire2", obs_main());
        end

        // Reset in EXPIRED
        drive(1, 0, 0, 1);
        exp_q.push_back(mk(3, 0, 0, 0, LD));
        step;
        chk("reset_expired", obs_main());

        drive(0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_timer.md
ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100000000, clk cycles per game second; legal range 2..2^27.
REQ-002 Parameter ROUND_SECONDS, default 60, round length in seconds; legal range 1..99.
REQ-003 clk  input  1  system clock; all state updates on the rising edge; one clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 gamemenu  input  1  game-state FSM menu indication (level).
REQ-006 gamerun  input  1  game-state FSM run indication (level).
REQ-007 gamepause  input  1  game-state FSM pause indication (level).
REQ-008 sec_tens  output  4  remaining seconds, tens digit, BCD 0..9.
REQ-009 sec_ones  output  4  remaining seconds, ones digit, BCD 0..9.
REQ-010 tick_1hz  output  1  one-cycle pulse on each decrement of the count.
REQ-011 time_up  output  1  level, high while the round has expired.
REQ-012 time_up_pulse  output  1  one-cycle pulse on the expiry transition.

Function
REQ-013 Effective mode per cycle, priority menu > pause > run: menu if gamemenu=1; else pause if gamepause=1; else run if gamerun=1; else hold (treated as pause).
REQ-014 States: LOADED, COUNTING, PAUSED, EXPIRED; all outputs registered, no combinational input-to-output path.
REQ-015 Menu mode from any state: next state LOADED, count = ROUND_SECONDS in BCD, prescaler = 0, time_up = 0, no pulses.
REQ-016 Run mode in LOADED/PAUSED/COUNTING: next state COUNTING; prescaler increments by 1 per cycle.
REQ-017 When prescaler = TICKS_PER_SEC-1 in run mode: prescaler wraps to 0, count decrements by one, tick_1hz = 1 the following cycle (same edge as the new count).
REQ-018 BCD decrement: ones=0 -> ones=9 and tens=tens-1; otherwise ones=ones-1; digits never hold values above 9.
REQ-019 Decrement from 01 to 00: next state EXPIRED, time_up = 1, time_up_pulse = 1 for exactly that cycle, tick_1hz also = 1 that cycle.
REQ-020 Pause/hold mode in LOADED/COUNTING/PAUSED: next state PAUSED (LOADED stays LOADED); prescaler and count frozen; no pulses.
REQ-021 Resuming from PAUSED continues the prescaler from its frozen value; a full second is not restarted.
REQ-022 EXPIRED: count held at 00, prescaler held at 0, time_up held 1, no tick_1hz; only menu mode or reset leaves EXPIRED.
REQ-023 Menu and a prescaler terminal count in the same cycle: menu wins, no tick, count reloads.
REQ-024 Prescaler width = ceil(log2(TICKS_PER_SEC)); it never exceeds TICKS_PER_SEC-1.
REQ-025 Round of N seconds in uninterrupted run mode: time_up rises exactly N*TICKS_PER_SEC cycles after the first run-mode cycle.

Reset
REQ-026 reset=1 at a clock edge: state LOADED, count = ROUND_SECONDS in BCD, prescaler 0, time_up 0, tick_1hz 0, time_up_pulse 0; reset overrides all inputs.
REQ-027 Reset asserted mid-round or in EXPIRED gives the same result as REQ-026; counting restarts only on run mode after reset deasserts.

Verification (TICKS_PER_SEC=4, ROUND_SECONDS=3 unless stated)
REQ-028 Reset, then gamerun=1 held -> sec 03; tick_1hz at cycles 4, 8, 12 after run start; sec 02, 01, 00; time_up and time_up_pulse rise at cycle 12; pulse lasts 1 cycle.
REQ-029 Run 6 cycles, gamepause=1 for 10 cycles, run again -> sec stays 02 during pause, no ticks; next tick 2 run cycles after resume.
REQ-030 Expire, hold gamerun=1 for 20 cycles -> sec 00, time_up 1, no further ticks; then gamemenu=1 one cycle -> sec 03, time_up 0.
REQ-031 ROUND_SECONDS=10, run -> first tick gives sec 09 (tens 0, ones 9), not 0F.
REQ-032 gamemenu=1 in the cycle prescaler=3 during run -> no tick, sec 03, prescaler 0; gamerun=1 with gamepause=1 -> frozen.
REQ-033 reset=1 for one cycle while sec=01 mid-second -> sec 03, time_up 0, no pulses; default parameters: first tick after exactly 100000000 run cycles, sec 59.
